pwm_output_stage: RTL and testbench

//  Consumes the five configuration bytes written over SPI (output enables, PWM enables,

---
 rtl/pwm_output_stage_if.sv | 22 ++
 rtl/pwm_output_stage.sv | 58 +++++
 tb/tb_pwm_output_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_output_stage_if.sv
// Configuration bytes from the SPI register block and the registered pin drive.
// The upstream block holds the inputs stable between writes, so there is no handshake.
interface pwm_output_stage_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
    logic       period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out_7_0, out_15_8, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out_7_0, out_15_8, period_start
    );
endinterface

// File: rtl/pwm_output_stage.sv
// 16-pin output stage: each pin off, static high or driven by a shared 8-bit PWM.
// Latency 1 clk from inputs/counter state to pins; free-running, no backpressure.
module pwm_output_stage #(
    parameter int CLK_DIV = 3000
) (
    input  logic                clk,
    input  logic                rst,
    pwm_output_stage_if.slave   bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc_cnt;
    logic [7:0]    r_pwm_cnt;
    logic [7:0]    r_duty_sh;
    logic [15:0]   r_out;
    logic          r_period_start;

    logic          w_tick;
    logic          w_wrap;
    logic          w_pwm_lvl;
    logic [15:0]   w_en_out;
    logic [15:0]   w_en_pwm;

    assign w_tick    = (r_presc_cnt == PRESC_MAX);
    assign w_wrap    = w_tick && (r_pwm_cnt == 8'hFF);
    // Full scale is forced high so 8'hFF gives no one-tick low gap per period.
    assign w_pwm_lvl = (r_duty_sh == 8'hFF) || (r_pwm_cnt < r_duty_sh);
    assign w_en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt    <= '0;
            r_pwm_cnt      <= 8'd0;
            r_duty_sh      <= 8'd0;
            r_out          <= 16'd0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc_cnt <= '0;
                r_pwm_cnt   <= r_pwm_cnt + 8'd1;
            end else begin
                r_presc_cnt <= r_presc_cnt + PW'(1);
            end
            // Duty only moves on the wrap edge so a period never mixes two duties.
            if (w_wrap) begin
                r_duty_sh <= bus.pwm_duty_cycle;
            end
            r_period_start <= w_wrap;
            r_out          <= w_en_out & (~w_en_pwm | {16{w_pwm_lvl}});
        end
    end

    assign bus.out_7_0      = r_out[7:0];
    assign bus.out_15_8     = r_out[15:8];
    assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Scenario bench for pwm_output_stage: per-cycle scoreboard plus per-feature checks.
module tb_pwm_output_stage;
    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] sb_q[$];

    pwm_output_stage_if bus ();

    pwm_output_stage #(.CLK_DIV(CLK_DIV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference model: position in the period is derived from edges since reset.
    int          m_t = 0;
    logic [7:0]  m_duty = 8'd0;
    initial begin
        int          cnt;
        bit          lvl;
        bit          ps;
        logic [15:0] eo;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_t    = 0;
                m_duty = 8'd0;
                sb_q.push_back(17'd0);
            end else begin
                cnt = (m_t / CLK_DIV) % 256;
                lvl = (m_duty == 8'hFF) || (cnt < int'(m_duty));
                eo  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0} &
                      (~{bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0} | {16{lvl}});
                ps  = ((m_t + 1) % PERIOD) == 0;
                if (ps) m_duty = bus.pwm_duty_cycle;
                m_t = m_t + 1;
                sb_q.push_back({eo, ps});
            end
        end
    end

    initial begin
        logic [16:0] exp_v;
        logic [16:0] got_v;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                got_v = {bus.out_15_8, bus.out_7_0, bus.period_start};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, got_v, exp_v);
                end
            end
        end
    end

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = d;
    endtask

    task automatic wait_ps(output int n);
        n = -1;
        for (int c = 1; c <= PERIOD + 64; c++) begin
            @(negedge clk);
            if (bus.period_start === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    function automatic logic [15:0] pins();
        return {bus.out_15_8, bus.out_7_0};
    endfunction

    task automatic test_reset;
        int n;
        rst = 1'b1;
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        repeat (3) @(negedge clk);
        checks++;
        if (pins() !== 16'h0000 || bus.period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pins=%h ps=%b expected pins=0000 ps=0", pins(), bus.period_start);
        end
        rst = 1'b0;
        wait_ps(n);
        checks++;
        if (n != PERIOD) begin
            errors++;
            $display("FAIL first_period_start got=%0d clk expected=%0d clk", n, PERIOD);
        end
    endtask

    task automatic test_static;
        int bad = 0;
        set_cfg(16'h00FF, 16'h0000, 8'hFF);
        @(negedge clk);
        checks++;
        if (bus.out_7_0 !== 8'hFF || bus.out_15_8 !== 8'h00) begin
            errors++;
            $display("FAIL static_1clk got lo=%h hi=%h expected lo=ff hi=00", bus.out_7_0, bus.out_15_8);
        end
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(negedge clk);
            if (pins() !== 16'h00FF) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL static_hold got %0d deviating clk expected 0", bad);
        end
    endtask

    task automatic test_duty_half;
        int n;
        int hi = 0;
        int lo = 0;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL half_period_start got timeout expected a pulse");
        end
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            if (pins() === 16'hFFFF) hi++;
            if (pins() === 16'h0000) lo++;
        end
        checks++;
        if (hi != 256 || lo != 256) begin
            errors++;
            $display("FAIL half_duty got high=%0d low=%0d expected high=256 low=256", hi, lo);
        end
    endtask

    task automatic test_duty_extremes;
        int n;
        int bad = 0;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps(n);
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(negedge clk);
            if (pins() !== 16'h0000) bad++;
        end
        checks++;
        if (n < 0 || bad != 0) begin
            errors++;
            $display("FAIL duty_zero got n=%0d high_clk=%0d expected n>0 high_clk=0", n, bad);
        end
        bad = 0;
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(n);
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(negedge clk);
            if (pins() !== 16'hFFFF) bad++;
        end
        checks++;
        if (n < 0 || bad != 0) begin
            errors++;
            $display("FAIL duty_full got n=%0d low_clk=%0d expected n>0 low_clk=0", n, bad);
        end
    endtask

    task automatic test_duty_change;
        int n;
        int hi = 0;
        int total = 0;
        bit seen = 0;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(n);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            total++;
            if (pins() === 16'hFFFF) hi++;
        end
        set_cfg(16'hFFFF, 16'hFFFF, 8'hC0);
        for (int c = 0; c < PERIOD && !seen; c++) begin
            @(negedge clk);
            total++;
            if (pins() === 16'hFFFF) hi++;
            if (bus.period_start === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || total != PERIOD || hi != 128) begin
            errors++;
            $display("FAIL change_old_period got len=%0d high=%0d expected len=%0d high=128", total, hi, PERIOD);
        end
        hi = 0;
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            if (pins() === 16'hFFFF) hi++;
        end
        checks++;
        if (hi != 384 || bus.period_start !== 1'b1) begin
            errors++;
            $display("FAIL change_new_period got high=%0d ps=%b expected high=384 ps=1", hi, bus.period_start);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int hi = 0;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(n);
        repeat (100) @(negedge clk);
        checks++;
        if (pins() !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_pre_reset got pins=%h expected ffff", pins());
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pins() !== 16'h0000 || bus.period_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got pins=%h ps=%b expected pins=0000 ps=0", pins(), bus.period_start);
        end
        rst = 1'b0;
        n = -1;
        for (int c = 1; c <= PERIOD + 64; c++) begin
            @(negedge clk);
            if (pins() !== 16'h0000) hi++;
            if (bus.period_start === 1'b1) begin
                n = c;
                break;
            end
        end
        checks++;
        if (n != PERIOD || hi != 0) begin
            errors++;
            $display("FAIL mid_restart got wrap=%0d high_clk=%0d expected wrap=%0d high_clk=0", n, hi, PERIOD);
        end
        @(negedge clk);
        checks++;
        if (pins() !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_reload got pins=%h expected ffff", pins());
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_duty_half();
        test_duty_extremes();
        test_duty_change();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
